seg_scan_mux: RTL and testbench

Time-multiplexed scanner for the four-digit seven-segment display. Holds a 16-bit, four-nibble display value and rotates through digits 0–3 at a programmable refresh rate. For each slot it drives the selected nibble onto A/B/C/D of the downstream `SegmentDisplay` decoder, together with the matching active-low anode and decimal point. New values are double-buffered and applied only at frame boundaries, so the display never tears.

---
 rtl/seg_scan_mux.sv | 158 +++++++++++++++
 tb/tb_seg_scan_mux.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// seg_scan_mux
// Time-multiplexed scanner for a four-digit seven-segment display.
// Holds a double-buffered 16-bit value, rotates through digits 0..3 with a
// programmable slot length and a short all-anodes-off guard at the start of
// each slot. New values are only applied at the frame wrap (digit 3 -> 0).
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   enable      1 = scan runs; 0 = counters hold and all anodes are off
//   load        one-cycle strobe capturing value/dp_en
//   value       four nibbles, [3:0] = digit 0 (AN0) ... [15:12] = digit 3 (AN3)
//   dp_en       per-digit decimal point enable, bit i = digit i
//   blank_lz    leading-zero blanking enable
//   A,B,C,D     nibble to the downstream decoder, A = MSB
//   dp          decimal point, active low
//   AN0..AN3    digit anodes, active low
//   frame_tick  one-cycle pulse on the pins when the new frame starts
module seg_scan_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_en,
  input  logic        blank_lz,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        dp,
  output logic        AN0,
  output logic        AN1,
  output logic        AN2,
  output logic        AN3,
  output logic        frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   act_val;
  logic [3:0]    act_dp;
  logic [15:0]   pend_val;
  logic [3:0]    pend_dp;
  logic          pend_flag;
  logic          wrapped;

  logic [3:0]    an_q;
  logic [3:0]    nib_q;
  logic          dp_q;
  logic          tick_q;

  logic          slot_end;
  logic          wrap;
  logic [3:0]    nib;
  logic          higher_zero;
  logic          blanked;

  // Slot and frame boundaries. A wrap only happens while the scan is running,
  // so a disabled scanner never swaps buffers.
  always_comb begin
    slot_end = (cnt == CW'(REFRESH_DIV - 1));
    wrap     = enable && slot_end && (idx == 2'd3);
  end

  // Select the current digit's nibble and decide whether it is a leading zero.
  // A digit is blank when it and every digit to its left are zero; digit 0
  // always shows so a zero value still displays "0".
  always_comb begin
    nib         = 4'h0;
    higher_zero = 1'b0;
    case (idx)
      2'd0: begin
        nib         = act_val[3:0];
        higher_zero = 1'b0;
      end
      2'd1: begin
        nib         = act_val[7:4];
        higher_zero = (act_val[15:4] == 12'h000);
      end
      2'd2: begin
        nib         = act_val[11:8];
        higher_zero = (act_val[15:8] == 8'h00);
      end
      default: begin
        nib         = act_val[15:12];
        higher_zero = (act_val[15:12] == 4'h0);
      end
    endcase
    blanked = blank_lz && higher_zero;
  end

  // Scan counters, buffers and registered pins. The pins are computed from
  // the state before the edge, so they run one cycle behind cnt/idx; the
  // frame tick is delayed once more so it lines up with the first digit-0
  // pins from the freshly swapped buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= 2'd0;
      act_val   <= 16'h0000;
      act_dp    <= 4'h0;
      pend_val  <= 16'h0000;
      pend_dp   <= 4'h0;
      pend_flag <= 1'b0;
      wrapped   <= 1'b0;
      an_q      <= 4'hF;
      nib_q     <= 4'h0;
      dp_q      <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      if (enable) begin
        if (slot_end) begin
          cnt <= '0;
          idx <= idx + 2'd1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      // A load on the wrap cycle goes straight to the active buffer and
      // supersedes anything pending; otherwise it just refreshes pending.
      if (load) begin
        if (wrap) begin
          act_val   <= value;
          act_dp    <= dp_en;
          pend_flag <= 1'b0;
        end else begin
          pend_val  <= value;
          pend_dp   <= dp_en;
          pend_flag <= 1'b1;
        end
      end else if (wrap && pend_flag) begin
        act_val   <= pend_val;
        act_dp    <= pend_dp;
        pend_flag <= 1'b0;
      end

      wrapped <= wrap;
      tick_q  <= wrapped;

      an_q  <= (enable && (cnt >= CW'(GUARD))) ? ~(4'b0001 << idx) : 4'hF;
      nib_q <= blanked ? 4'hF : nib;
      dp_q  <= blanked ? 1'b1 : ~act_dp[idx];
    end
  end

  assign {A, B, C, D}         = nib_q;
  assign dp                   = dp_q;
  assign {AN3, AN2, AN1, AN0} = an_q;
  assign frame_tick           = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux
// Scoreboarded bench for seg_scan_mux with REFRESH_DIV=8, GUARD=2. A
// reference model tracks the scan as a single frame position and pushes
// the expected pin values for every clock edge into a queue; a monitor pops
// and compares on the falling edge. Directed scenarios add fixed-value
// checks, then a randomized phase runs against the model.
module tb_seg_scan_mux;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic        blank_lz;
  logic        A, B, C, D, dp, AN0, AN1, AN2, AN3, frame_tick;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] an;
    logic [3:0] nib;
    logic       dpv;
    logic       tick;
  } exp_t;

  exp_t sbq[$];

  // model state
  int          m_pos     = 0;
  logic [15:0] m_val     = 16'h0;
  logic [3:0]  m_dp      = 4'h0;
  logic [15:0] m_pval    = 16'h0;
  logic [3:0]  m_pdp     = 4'h0;
  bit          m_pf      = 1'b0;
  bit          m_wrapped = 1'b0;
  bit          m_live    = 1'b0;

  seg_scan_mux #(.REFRESH_DIV(DIV), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value),
    .dp_en(dp_en), .blank_lz(blank_lz),
    .A(A), .B(B), .C(C), .D(D), .dp(dp),
    .AN0(AN0), .AN1(AN1), .AN2(AN2), .AN3(AN3), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] dutNib();
    return {A, B, C, D};
  endfunction

  function automatic logic [3:0] dutAn();
    return {AN3, AN2, AN1, AN0};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Sets the load strobe/data for one cycle, then drops the strobe.
  task automatic applyStimulus(input bit ld, input logic [15:0] v, input logic [3:0] d);
    load  = ld;
    value = v;
    dp_en = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic waitPos(input int p);
    int n = 0;
    while (m_pos != p && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("waitPos reached", 16'(m_pos), 16'(p));
  endtask

  task automatic waitTick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 200);
    checkOutput("frame_tick seen", {15'h0, frame_tick}, 16'h1);
  endtask

  // Reference model: one frame position 0..FRAME-1 stands for slot and
  // in-slot count; pins at each edge come from the model state before it.
  initial begin
    exp_t e;
    int   slot, phase;
    bit   wrap, blk;
    forever begin
      @(posedge clk);
      if (rst === 1'b1) begin
        e.an = 4'hF; e.nib = 4'h0; e.dpv = 1'b1; e.tick = 1'b0;
        sbq.push_back(e);
        m_pos = 0; m_val = 0; m_dp = 0; m_pval = 0; m_pdp = 0;
        m_pf = 0; m_wrapped = 0; m_live = 1;
      end else if (m_live) begin
        slot  = m_pos / DIV;
        phase = m_pos % DIV;
        blk   = blank_lz && slot > 0 && ((m_val >> (4 * slot)) == 16'h0);
        e.an   = (enable && phase >= GUARD) ? ~(4'b0001 << slot) : 4'hF;
        e.nib  = blk ? 4'hF : 4'((m_val >> (4 * slot)) & 16'hF);
        e.dpv  = blk ? 1'b1 : ~m_dp[slot];
        e.tick = m_wrapped;
        sbq.push_back(e);
        wrap = enable && (m_pos == FRAME - 1);
        m_wrapped = wrap;
        if (load && wrap) begin
          m_val = value; m_dp = dp_en; m_pf = 0;
        end else if (load) begin
          m_pval = value; m_pdp = dp_en; m_pf = 1;
        end else if (wrap && m_pf) begin
          m_val = m_pval; m_dp = m_pdp; m_pf = 0;
        end
        if (enable) m_pos = (m_pos + 1) % FRAME;
      end
    end
  end

  // Monitor: one expected entry per edge, compared half a cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkOutput("anodes", {12'h0, dutAn()}, {12'h0, e.an});
      checkOutput("nibble", {12'h0, dutNib()}, {12'h0, e.nib});
      checkOutput("dp", {15'h0, dp}, {15'h0, e.dpv});
      checkOutput("frame_tick", {15'h0, frame_tick}, {15'h0, e.tick});
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ticks[$];
    int nz;
    rst = 1'b1; enable = 1'b1; load = 1'b0; value = 16'h0; dp_en = 4'h0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset and scan timing
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput("reset pins nibble", {12'h0, dutNib()}, 16'h0);
      if (k == 2) checkOutput("an edge2", {12'h0, dutAn()}, 16'hF);
      if (k == 3) checkOutput("an edge3", {12'h0, dutAn()}, 16'hE);
      if (k == 9) checkOutput("an edge9", {12'h0, dutAn()}, 16'hF);
      if (k == 11) checkOutput("an edge11", {12'h0, dutAn()}, 16'hD);
      if (frame_tick === 1'b1) ticks.push_back(k);
    end
    checkOutput("tick count", 16'(ticks.size()), 16'd2);
    if (ticks.size() == 2) begin
      checkOutput("first tick edge", 16'(ticks[0]), 16'd33);
      checkOutput("second tick edge", 16'(ticks[1]), 16'd65);
    end

    // double buffering
    waitPos(4);
    applyStimulus(1'b1, 16'h1234, 4'h0);
    waitTick();
    checkOutput("dbuf digit0", {12'h0, dutNib()}, 16'h4);
    repeat (8) @(negedge clk);
    checkOutput("dbuf digit1", {12'h0, dutNib()}, 16'h3);
    repeat (8) @(negedge clk);
    checkOutput("dbuf digit2", {12'h0, dutNib()}, 16'h2);
    repeat (8) @(negedge clk);
    checkOutput("dbuf digit3", {12'h0, dutNib()}, 16'h1);

    // last load wins, then load exactly on the wrap cycle
    waitPos(3);
    applyStimulus(1'b1, 16'h0005, 4'h0);
    waitPos(10);
    applyStimulus(1'b1, 16'h0009, 4'h0);
    waitTick();
    checkOutput("last load wins", {12'h0, dutNib()}, 16'h9);
    waitPos(FRAME - 1);
    applyStimulus(1'b1, 16'h0007, 4'h0);
    @(negedge clk);
    checkOutput("wrap load tick", {15'h0, frame_tick}, 16'h1);
    checkOutput("wrap load digit0", {12'h0, dutNib()}, 16'h7);

    // enable hold during digit 2
    applyStimulus(1'b1, 16'h4321, 4'h0);
    waitTick();
    waitPos(20);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("hold anodes off", {12'h0, dutAn()}, 16'hF);
      checkOutput("hold digit2 nibble", {12'h0, dutNib()}, 16'h3);
    end
    enable = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("resume still digit2", {12'h0, dutAn()}, 16'hB);

    // leading-zero blanking
    blank_lz = 1'b1;
    applyStimulus(1'b1, 16'h0040, 4'hF);
    waitTick();
    checkOutput("lz digit0 nib", {12'h0, dutNib()}, 16'h0);
    checkOutput("lz digit0 dp", {15'h0, dp}, 16'h0);
    repeat (8) @(negedge clk);
    checkOutput("lz digit1 nib", {12'h0, dutNib()}, 16'h4);
    checkOutput("lz digit1 dp", {15'h0, dp}, 16'h0);
    repeat (8) @(negedge clk);
    checkOutput("lz digit2 nib", {12'h0, dutNib()}, 16'hF);
    checkOutput("lz digit2 dp", {15'h0, dp}, 16'h1);
    repeat (8) @(negedge clk);
    checkOutput("lz digit3 nib", {12'h0, dutNib()}, 16'hF);
    checkOutput("lz digit3 dp", {15'h0, dp}, 16'h1);
    applyStimulus(1'b1, 16'h0000, 4'hF);
    waitTick();
    checkOutput("zero digit0 nib", {12'h0, dutNib()}, 16'h0);
    repeat (8) @(negedge clk);
    checkOutput("zero digit1 nib", {12'h0, dutNib()}, 16'hF);

    // reset mid-frame discards pending data
    blank_lz = 1'b0;
    waitPos(12);
    applyStimulus(1'b1, 16'hABCD, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset anodes", {12'h0, dutAn()}, 16'hF);
    checkOutput("midreset nibble", {12'h0, dutNib()}, 16'h0);
    checkOutput("midreset dp", {15'h0, dp}, 16'h1);
    nz = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (dutNib() !== 4'h0) nz++;
    end
    checkOutput("pending discarded", 16'(nz), 16'h0);

    // randomized phase
    for (int k = 0; k < 1500; k++) begin
      rst    = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      applyStimulus($urandom_range(0, 5) == 0, 16'($urandom), 4'($urandom));
    end
    rst = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
